// File: rtl/jtag_dr_pkg.sv
// Shared types and widths for the system-clock JTAG user-DR sampler.
package jtag_dr_pkg;
  localparam int c_JTAG_DR_DATA_W = 8;
  localparam int c_JTAG_DR_ADDR_W = 3;
  localparam int c_JTAG_DR_CNT_W  = 5;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    CAPTURED = 2'd1,
    SHIFTING = 2'd2,
    EXIT     = 2'd3
  } dr_state_t;
endpackage

// File: rtl/jtag_dr_sync.sv
// Multi-stage synchronizer for one TAP signal; optionally emits a one-cycle
// rising-edge pulse instead of the synchronized level.
module jtag_dr_sync #(
  parameter int g_sync_stages = 2,
  parameter bit g_edge        = 1'b0
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_d,
  output logic o_q
);
  logic [g_sync_stages-1:0] r_sync;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_sync <= '0;
    else          r_sync <= {r_sync[g_sync_stages-2:0], i_d};
  end

  // Level and edge outputs come from the same stage so they stay cycle-aligned.
  generate
    if (g_edge) begin : g_rise
      logic r_prev;
      always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) r_prev <= 1'b0;
        else          r_prev <= r_sync[g_sync_stages-1];
      end
      assign o_q = r_sync[g_sync_stages-1] & ~r_prev;
    end else begin : g_level
      assign o_q = r_sync[g_sync_stages-1];
    end
  endgenerate
endmodule

// File: rtl/jtag_dr_sampler.sv
// Oversampled JTAG user DR (data + address) in the system clock domain.
// Define JTAG_DR_SAMPLER_LEN_CHECK_EN to reject updates of the wrong length.
module jtag_dr_sampler import jtag_dr_pkg::*; #(
  parameter int g_data_width  = c_JTAG_DR_DATA_W,
  parameter int g_addr_width  = c_JTAG_DR_ADDR_W,
  parameter int g_sync_stages = 2
) (
  input  logic                    clk_sys_i,
  input  logic                    rst_n_i,
  input  logic                    tck_i,
  input  logic                    tdi_i,
  output logic                    tdo_o,
  input  logic                    capture_i,
  input  logic                    shift_i,
  input  logic                    e1dr_i,
  input  logic                    update_i,
  input  logic                    reset_i,
  input  logic [g_data_width-1:0] reg_q_i,
  input  logic [g_addr_width-1:0] reg_addr_q_i,
  output logic [g_data_width-1:0] reg_d_o,
  output logic [g_addr_width-1:0] reg_addr_d_o,
  output logic                    reg_update_o,
  output logic                    len_err_o
);
  localparam int N = g_data_width + g_addr_width;

  logic w_tck_rise, w_upd_rise, w_tdi_s, w_cap_s, w_shift_s, w_e1dr_s, w_rst_s;

  jtag_dr_sync #(.g_sync_stages(g_sync_stages), .g_edge(1'b1)) u_sync_tck (
    .i_clk(clk_sys_i), .i_rst_n(rst_n_i), .i_d(tck_i), .o_q(w_tck_rise));
  jtag_dr_sync #(.g_sync_stages(g_sync_stages), .g_edge(1'b1)) u_sync_upd (
    .i_clk(clk_sys_i), .i_rst_n(rst_n_i), .i_d(update_i), .o_q(w_upd_rise));
  jtag_dr_sync #(.g_sync_stages(g_sync_stages), .g_edge(1'b0)) u_sync_tdi (
    .i_clk(clk_sys_i), .i_rst_n(rst_n_i), .i_d(tdi_i), .o_q(w_tdi_s));
  jtag_dr_sync #(.g_sync_stages(g_sync_stages), .g_edge(1'b0)) u_sync_cap (
    .i_clk(clk_sys_i), .i_rst_n(rst_n_i), .i_d(capture_i), .o_q(w_cap_s));
  jtag_dr_sync #(.g_sync_stages(g_sync_stages), .g_edge(1'b0)) u_sync_shift (
    .i_clk(clk_sys_i), .i_rst_n(rst_n_i), .i_d(shift_i), .o_q(w_shift_s));
  jtag_dr_sync #(.g_sync_stages(g_sync_stages), .g_edge(1'b0)) u_sync_e1dr (
    .i_clk(clk_sys_i), .i_rst_n(rst_n_i), .i_d(e1dr_i), .o_q(w_e1dr_s));
  jtag_dr_sync #(.g_sync_stages(g_sync_stages), .g_edge(1'b0)) u_sync_rst (
    .i_clk(clk_sys_i), .i_rst_n(rst_n_i), .i_d(reset_i), .o_q(w_rst_s));

  dr_state_t               r_state;
  logic [N-1:0]            r_shreg;
  logic                    r_tdo;
  logic [g_data_width-1:0] r_d;
  logic [g_addr_width-1:0] r_addr;
  logic                    r_upd;

`ifdef JTAG_DR_SAMPLER_LEN_CHECK_EN
  localparam logic [c_JTAG_DR_CNT_W-1:0] c_CNT_N = c_JTAG_DR_CNT_W'(N);
  logic [c_JTAG_DR_CNT_W-1:0] r_cnt;
  logic                       r_len_err;
`endif

  always_ff @(posedge clk_sys_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_state   <= IDLE;
      r_shreg   <= '0;
      r_tdo     <= 1'b0;
      r_d       <= '0;
      r_addr    <= '0;
      r_upd     <= 1'b0;
`ifdef JTAG_DR_SAMPLER_LEN_CHECK_EN
      r_cnt     <= '0;
      r_len_err <= 1'b0;
`endif
    end else begin
      r_upd <= 1'b0;
      r_tdo <= r_shreg[0];
      if (w_rst_s) begin
        r_state   <= IDLE;
        r_shreg   <= '0;
`ifdef JTAG_DR_SAMPLER_LEN_CHECK_EN
        r_cnt     <= '0;
        r_len_err <= 1'b0;
`endif
      end else if (w_tck_rise && w_cap_s) begin
        r_shreg <= {reg_q_i, reg_addr_q_i};
        r_state <= CAPTURED;
`ifdef JTAG_DR_SAMPLER_LEN_CHECK_EN
        r_cnt   <= '0;
`endif
      end else if (w_tck_rise && w_shift_s &&
                   (r_state == CAPTURED || r_state == SHIFTING)) begin
        r_shreg <= {w_tdi_s, r_shreg[N-1:1]};
        r_state <= SHIFTING;
`ifdef JTAG_DR_SAMPLER_LEN_CHECK_EN
        if (r_cnt != '1) r_cnt <= r_cnt + 1'b1;
`endif
      end else if (w_upd_rise) begin
        // An update without any shift since capture carries no new data.
        if (r_state == EXIT || r_state == SHIFTING) begin
`ifdef JTAG_DR_SAMPLER_LEN_CHECK_EN
          if (r_cnt == c_CNT_N) begin
            r_d    <= r_shreg[N-1:g_addr_width];
            r_addr <= r_shreg[g_addr_width-1:0];
            r_upd  <= 1'b1;
          end else begin
            r_len_err <= 1'b1;
          end
`else
          r_d    <= r_shreg[N-1:g_addr_width];
          r_addr <= r_shreg[g_addr_width-1:0];
          r_upd  <= 1'b1;
`endif
        end
        r_state <= IDLE;
      end else if (w_e1dr_s && r_state == SHIFTING) begin
        r_state <= EXIT;
      end
    end
  end

  assign tdo_o        = r_tdo;
  assign reg_d_o      = r_d;
  assign reg_addr_d_o = r_addr;
  assign reg_update_o = r_upd;
`ifdef JTAG_DR_SAMPLER_LEN_CHECK_EN
  assign len_err_o    = r_len_err;
`else
  assign len_err_o    = 1'b0;
`endif
endmodule

// File: tb/tb_jtag_dr_sampler.sv
// Bench for jtag_dr_sampler: directed vector table, hand sequences for resets
// and back-to-back transfers, and random whole-transfer checks.
module tb_jtag_dr_sampler;
  localparam int N = 11;

  logic       clk_sys_i = 1'b0, rst_n_i = 1'b0;
  logic       tck_i = 1'b0, tdi_i = 1'b0, capture_i = 1'b0, shift_i = 1'b0;
  logic       e1dr_i = 1'b0, update_i = 1'b0, reset_i = 1'b0;
  logic [7:0] reg_q_i = '0;
  logic [2:0] reg_addr_q_i = '0;
  logic       tdo_o, reg_update_o, len_err_o;
  logic [7:0] reg_d_o;
  logic [2:0] reg_addr_d_o;

  int total = 0, bad = 0;

  always #5 clk_sys_i = ~clk_sys_i;

  jtag_dr_sampler dut (
    .clk_sys_i(clk_sys_i), .rst_n_i(rst_n_i), .tck_i(tck_i), .tdi_i(tdi_i),
    .tdo_o(tdo_o), .capture_i(capture_i), .shift_i(shift_i), .e1dr_i(e1dr_i),
    .update_i(update_i), .reset_i(reset_i), .reg_q_i(reg_q_i),
    .reg_addr_q_i(reg_addr_q_i), .reg_d_o(reg_d_o), .reg_addr_d_o(reg_addr_d_o),
    .reg_update_o(reg_update_o), .len_err_o(len_err_o));

  // Strobe monitor: every pulse is logged with its cycle number.
  int         cyc = 0;
  logic [10:0] stb_q[$];
  int         stb_cyc[$];
  bit         consec = 1'b0;
  logic       prev_upd = 1'b0;
  always @(negedge clk_sys_i) begin
    cyc <= cyc + 1;
    if (reg_update_o) begin
      stb_q.push_back({reg_d_o, reg_addr_d_o});
      stb_cyc.push_back(cyc);
    end
    if (reg_update_o && prev_upd) consec <= 1'b1;
    prev_upd <= reg_update_o;
  end

  // Reference model: last delivered word and sticky length error.
  logic [7:0] m_d = '0;
  logic [2:0] m_a = '0;
  bit         m_le = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // One TCK period (8 clk low, 8 clk high); TAP signals change at the falling edge.
  task automatic tap_cyc(input bit cap, input bit sh, input bit e1, input bit upd,
                         input bit rs, input bit d, input bit chk_tdo, input bit exp_tdo);
    tck_i = 1'b0; capture_i = cap; shift_i = sh; e1dr_i = e1;
    update_i = upd; reset_i = rs; tdi_i = d;
    repeat (8) @(negedge clk_sys_i);
    if (chk_tdo) chk("tdo_bit", tdo_o, exp_tdo);
    tck_i = 1'b1;
    repeat (8) @(negedge clk_sys_i);
  endtask

  // Whole transfer: capture, n shifts of w (LSB first), optional exit1, update.
  // The DR after n shifts is simply ({w, captured} >> n) truncated to N bits.
  task automatic xfer(input logic [7:0] qd, input logic [2:0] qa, input logic [31:0] w,
                      input int n, input bit e1, input bit idle);
    logic [63:0] full;
    logic [10:0] rx;
    int          nstb;
    bit          exp_stb;
    reg_q_i = qd; reg_addr_q_i = qa;
    full = ({32'd0, w} << N) | 64'({qd, qa});
    nstb = stb_q.size();
    tap_cyc(1, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < n; i++) tap_cyc(0, 1, 0, 0, 0, w[i], 1, full[i]);
    if (e1) tap_cyc(0, 0, 1, 0, 0, 0, 0, 0);
    tap_cyc(0, 0, 0, 1, 0, 0, 0, 0);
    if (idle) tap_cyc(0, 0, 0, 0, 0, 0, 0, 0);
    rx = 11'(full >> n);
`ifdef JTAG_DR_SAMPLER_LEN_CHECK_EN
    exp_stb = (n == N);
    if (n != 0 && n != N) m_le = 1'b1;
`else
    exp_stb = (n != 0);
`endif
    if (exp_stb) begin m_d = rx[10:3]; m_a = rx[2:0]; end
    chk("strobe_count", stb_q.size() - nstb, exp_stb);
    if (exp_stb && stb_q.size() > nstb) chk("strobe_word", stb_q[stb_q.size()-1], rx);
    chk("reg_d_o", reg_d_o, m_d);
    chk("reg_addr_d_o", reg_addr_d_o, m_a);
    chk("len_err_o", len_err_o, m_le);
  endtask

  typedef struct {
    logic [7:0]  qd;
    logic [2:0]  qa;
    logic [31:0] w;
    int          n;
    bit          e1;
    logic [7:0]  exp_d;
    logic [2:0]  exp_a;
  } vec_t;

  initial begin
    vec_t vt[4];
    int   nstb, gap;
    vt[0] = '{8'hA5, 3'b110, 32'h1E3, 11, 1'b1, 8'h3C, 3'd3};
    vt[1] = '{8'h12, 3'b100, 32'h155,  0, 1'b1, 8'h3C, 3'd3};
    vt[2] = '{8'h00, 3'b000, 32'h7FF, 11, 1'b0, 8'hFF, 3'd7};
    vt[3] = '{8'h33, 3'b001, 32'h2D5, 11, 1'b1, 8'h5A, 3'd5};

    repeat (3) @(negedge clk_sys_i);
    chk("rst_tdo", tdo_o, 0);
    chk("rst_reg_d", reg_d_o, 0);
    chk("rst_reg_addr", reg_addr_d_o, 0);
    chk("rst_update", reg_update_o, 0);
    chk("rst_len_err", len_err_o, 0);
    rst_n_i = 1'b1;
    repeat (2) @(negedge clk_sys_i);

    foreach (vt[k]) begin
      xfer(vt[k].qd, vt[k].qa, vt[k].w, vt[k].n, vt[k].e1, 1'b1);
      chk("vec_d", reg_d_o, vt[k].exp_d);
      chk("vec_a", reg_addr_d_o, vt[k].exp_a);
    end

    // TAP reset after 5 shifts aborts the transfer; next full transfer lands.
    reg_q_i = 8'h5A; reg_addr_q_i = 3'd2;
    nstb = stb_q.size();
    tap_cyc(1, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 5; i++) tap_cyc(0, 1, 0, 0, 0, 1'b1, 0, 0);
    tap_cyc(0, 0, 0, 0, 1, 0, 0, 0);
    tap_cyc(0, 0, 0, 0, 0, 0, 0, 0);
    tap_cyc(0, 0, 0, 1, 0, 0, 0, 0);
    tap_cyc(0, 0, 0, 0, 0, 0, 0, 0);
    m_le = 1'b0;
    chk("tap_rst_no_strobe", stb_q.size() - nstb, 0);
    xfer(8'h00, 3'd0, 32'h7FF, 11, 1'b1, 1'b1);
    chk("tap_rst_word", {reg_d_o, reg_addr_d_o}, 11'h7FF);
    chk("tap_rst_one_strobe", stb_q.size() - nstb, 1);

    // rst_n_i during the 6th shift: immediate reset, remainder never delivered.
    reg_q_i = 8'hFF; reg_addr_q_i = 3'd7;
    tap_cyc(1, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 5; i++) tap_cyc(0, 1, 0, 0, 0, 1'b1, 1, 1'b1);
    tck_i = 1'b0; shift_i = 1'b1; tdi_i = 1'b1;
    repeat (3) @(negedge clk_sys_i);
    chk("pre_rst_tdo", tdo_o, 1);
    #2 rst_n_i = 1'b0;
    #1;
    chk("async_rst_tdo", tdo_o, 0);
    chk("async_rst_reg_d", reg_d_o, 0);
    chk("async_rst_reg_addr", reg_addr_d_o, 0);
    chk("async_rst_update", reg_update_o, 0);
    chk("async_rst_len_err", len_err_o, 0);
    @(negedge clk_sys_i);
    rst_n_i = 1'b1;
    repeat (4) @(negedge clk_sys_i);
    tck_i = 1'b1;
    repeat (8) @(negedge clk_sys_i);
    m_d = '0; m_a = '0; m_le = 1'b0;
    nstb = stb_q.size();
    for (int i = 0; i < 5; i++) tap_cyc(0, 1, 0, 0, 0, 1'b1, 0, 0);
    tap_cyc(0, 0, 1, 0, 0, 0, 0, 0);
    tap_cyc(0, 0, 0, 1, 0, 0, 0, 0);
    tap_cyc(0, 0, 0, 0, 0, 0, 0, 0);
    chk("partial_not_delivered", stb_q.size() - nstb, 0);
    chk("partial_reg_d", reg_d_o, 0);
    xfer(8'h3C, 3'd5, 32'h4B2, 11, 1'b1, 1'b1);

    // Back-to-back transfers with capture immediately after update.
    nstb = stb_q.size();
    xfer(8'h10, 3'd2, 32'h009, 11, 1'b1, 1'b0);
    xfer(8'h20, 3'd4, 32'h012, 11, 1'b1, 1'b1);
    chk("b2b_count", stb_q.size() - nstb, 2);
    if (stb_q.size() >= nstb + 2) begin
      gap = stb_cyc[nstb+1] - stb_cyc[nstb];
      chk("b2b_gap_ok", gap >= 2, 1);
      chk("b2b_first", stb_q[nstb], 11'h009);
      chk("b2b_second", stb_q[nstb+1], 11'h012);
    end

    // 10-bit transfer: rejected with sticky error, or delivered as shifted.
`ifdef JTAG_DR_SAMPLER_LEN_CHECK_EN
    xfer(8'h00, 3'd0, 32'h3FF, 10, 1'b1, 1'b1);
    chk("len_err_set", len_err_o, 1);
    xfer(8'hC3, 3'd1, 32'h61E, 11, 1'b1, 1'b1);
    chk("len_err_sticky", len_err_o, 1);
    tap_cyc(0, 0, 0, 0, 1, 0, 0, 0);
    tap_cyc(0, 0, 0, 0, 0, 0, 0, 0);
    m_le = 1'b0;
    chk("len_err_cleared", len_err_o, 0);
`else
    xfer(8'h00, 3'd0, 32'h3FF, 10, 1'b1, 1'b1);
    chk("short_word", {reg_d_o, reg_addr_d_o}, 11'h7FE);
    chk("len_err_tied", len_err_o, 0);
`endif

    for (int r = 0; r < 20; r++)
      xfer(8'($urandom), 3'($urandom), $urandom, $urandom_range(0, 13),
           1'($urandom), 1'b1);

    chk("no_consecutive_strobes", consec, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
